// File: rtl/bird_pkg.sv
// Shared constants for the bird physics block: default widths, screen bounds
// and the game-state encoding seen by the renderer.
package bird_pkg;

  localparam int Y_W    = 10;
  localparam int FRAC_W = 4;
  localparam int V_W    = 8;

  localparam int Y_MIN  = 0;
  localparam int Y_MAX  = 480;
  localparam int Y_INIT = 240;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLYING = 2'd1,
    ST_DEAD   = 2'd2
  } state_e;

endpackage

// File: rtl/bird_physics_if.sv
// Control inputs and renderer-facing outputs of bird_physics.
// master = game controller / bench side, slave = bird_physics.
interface bird_physics_if #(
  parameter int Y_W = bird_pkg::Y_W,
  parameter int V_W = bird_pkg::V_W
);

  logic                  tick;
  logic                  start;
  logic                  flap;
  logic                  collide;
  logic [Y_W-1:0]        y;
  logic signed [V_W-1:0] vel;
  logic [1:0]            state;
  logic                  dead;

  modport master (
    output tick, start, flap, collide,
    input  y, vel, state, dead
  );

  modport slave (
    input  tick, start, flap, collide,
    output y, vel, state, dead
  );

endinterface

// File: rtl/bird_physics_flap_latch.sv
// Flap button edge detect and pending-flap latch consumed on the frame tick.
// Optional flap lockout counter enabled by BIRD_FLAP_COOLDOWN_EN.
module flap_latch #(
  parameter int COOLDOWN_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flap_i,
  input  logic accept_i,
  input  logic consume_i,
  input  logic clear_i,
  output logic rise_o,
  output logic take_flap_o
);

  logic flap_q;
  logic pending_q;
  logic rise_raw;
  logic rise_ok;

  assign rise_raw = flap_i & ~flap_q;

`ifdef BIRD_FLAP_COOLDOWN_EN
  localparam int CW = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS + 1) : 1;

  logic [CW-1:0] cnt_q;

  assign rise_ok = rise_raw & accept_i & (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (rise_ok) begin
      cnt_q <= CW'(COOLDOWN_TICKS);
    end else if (consume_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end
`else
  // No lockout: the parameter only shapes the optional counter.
  assign rise_ok = rise_raw & accept_i & (COOLDOWN_TICKS >= 0);
`endif

  // A rise in the same cycle as the tick is taken immediately.
  assign rise_o      = rise_ok;
  assign take_flap_o = pending_q | rise_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      flap_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      flap_q <= flap_i;
      if (clear_i || consume_i) begin
        pending_q <= 1'b0;
      end else if (rise_ok) begin
        pending_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bird_physics.sv
// Fixed-point bird vertical motion with IDLE/FLYING/DEAD game state.
// Optional flap cooldown: define BIRD_FLAP_COOLDOWN_EN.
module bird_physics import bird_pkg::*; #(
  parameter int Y_W            = bird_pkg::Y_W,
  parameter int FRAC_W         = bird_pkg::FRAC_W,
  parameter int V_W            = bird_pkg::V_W,
  parameter int Y_MIN          = bird_pkg::Y_MIN,
  parameter int Y_MAX          = bird_pkg::Y_MAX,
  parameter int Y_INIT         = bird_pkg::Y_INIT,
  parameter int GRAVITY        = 8,
  parameter int FLAP_VEL       = 64,
  parameter int V_TERM         = 96,
  parameter int COOLDOWN_TICKS = 4
) (
  input  logic          clk,
  input  logic          rst,
  bird_physics_if.slave bus
);

  localparam int PW = Y_W + FRAC_W + 1;

  localparam logic signed [PW:0]   P_MIN   = (PW+1)'(Y_MIN * (2**FRAC_W));
  localparam logic signed [PW:0]   P_MAX   = (PW+1)'(Y_MAX * (2**FRAC_W));
  localparam logic signed [PW-1:0] P_SPAWN = PW'(Y_INIT * (2**FRAC_W));
  localparam logic signed [V_W:0]  V_GRAV  = (V_W+1)'(GRAVITY);
  localparam logic signed [V_W:0]  V_FLAP  = (V_W+1)'(FLAP_VEL);
  localparam logic signed [V_W:0]  V_FLOOR = (V_W+1)'(-V_TERM);

  state_e                state_q;
  logic signed [PW-1:0]  pos_q;
  logic signed [V_W-1:0] vel_q;
  logic                  dead_q;

  logic                  flying, rise, take_flap, take;
  logic                  accept, consume, clear;
  logic signed [V_W:0]   v_grav, v_fall, v1;
  logic signed [PW:0]    p1;
  logic                  hit_floor, hit_ceil;
  logic signed [PW-1:0]  pos_tick_d;
  logic signed [V_W-1:0] vel_tick_d;

  assign flying  = (state_q == ST_FLYING);
  assign accept  = (state_q != ST_DEAD);
  assign consume = bus.tick & flying;
  assign clear   = (state_q == ST_DEAD) | (flying & (bus.collide | (bus.tick & hit_floor)));

  flap_latch #(
    .COOLDOWN_TICKS(COOLDOWN_TICKS)
  ) u_flap_latch (
    .clk        (clk),
    .rst        (rst),
    .flap_i     (bus.flap),
    .accept_i   (accept),
    .consume_i  (consume),
    .clear_i    (clear),
    .rise_o     (rise),
    .take_flap_o(take_flap)
  );

  // One guard bit on every sum so the clamps see the true value.
  assign take     = take_flap & flying & ~bus.collide;
  assign v_grav   = {vel_q[V_W-1], vel_q} - V_GRAV;
  assign v_fall   = (v_grav < V_FLOOR) ? V_FLOOR : v_grav;
  assign v1       = take ? V_FLAP : v_fall;
  assign p1       = {pos_q[PW-1], pos_q} + {{(PW-V_W){v1[V_W]}}, v1};
  assign hit_floor = (p1 <= P_MIN);
  assign hit_ceil  = (p1 >= P_MAX);

  assign pos_tick_d = hit_floor ? P_MIN[PW-1:0] : (hit_ceil ? P_MAX[PW-1:0] : p1[PW-1:0]);
  assign vel_tick_d = (hit_floor || hit_ceil) ? '0 : v1[V_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pos_q   <= P_SPAWN;
      vel_q   <= '0;
      dead_q  <= 1'b0;
    end else begin
      dead_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start || rise) state_q <= ST_FLYING;
        end
        ST_FLYING: begin
          if (bus.tick) begin
            pos_q <= pos_tick_d;
            vel_q <= vel_tick_d;
            if (hit_floor) begin
              state_q <= ST_DEAD;
              dead_q  <= 1'b1;
            end
          end
          if (bus.collide) begin
            state_q <= ST_DEAD;
            dead_q  <= 1'b1;
          end
        end
        ST_DEAD: begin
          if (bus.start) begin
            state_q <= ST_IDLE;
            pos_q   <= P_SPAWN;
            vel_q   <= '0;
          end else if (bus.tick) begin
            pos_q <= pos_tick_d;
            vel_q <= vel_tick_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.y     = pos_q[Y_W+FRAC_W-1:FRAC_W];
  assign bus.vel   = vel_q;
  assign bus.state = state_q;
  assign bus.dead  = dead_q;

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: reset, free fall, flap timing, ceiling,
// ground/collide death and mid-flight reset, with hand-computed expectations.
module tb_bird_physics;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  bird_physics_if bus ();

  bird_physics dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests    = 0;
  int fails    = 0;
  int dead_cnt = 0;

  always @(negedge clk) if (bus.dead === 1'b1) dead_cnt++;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    $display("[TB] %s obs=%0d exp=%0d", tag, obs, exp);
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int y, input int v, input int s);
    check({tag, ".y"},     int'(bus.y),          y);
    check({tag, ".vel"},   int'($signed(bus.vel)), v);
    check({tag, ".state"}, int'(bus.state),      s);
  endtask

  task automatic tick_step();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    bus.tick    = 1'b0;
    bus.start   = 1'b0;
    bus.flap    = 1'b0;
    bus.collide = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    int n;
    int d0;

    // Reset state
    do_reset();
    check_out("reset", 240, 0, 0);
    check("reset.dead", int'(bus.dead), 0);

    // Free fall from spawn
    start_pulse();
    check("start.state", int'(bus.state), 1);
    tick_step();
    check_out("fall1", 239, -8, 1);
    repeat (12) tick_step();
    check_out("fall13", 195, -96, 1);
    tick_step();
    check_out("fall14", 189, -96, 1);

    // Flap latched 3 clks ahead, then a rise coincident with the tick
    do_reset();
    start_pulse();
    bus.flap = 1'b1;
    step(3);
    tick_step();
    check_out("flap_early", 244, 64, 1);
    bus.flap = 1'b0;
    step();
    bus.flap = 1'b1;
    tick_step();
    bus.flap = 1'b0;
    check_out("flap_coinc", 248, 64, 1);

    // Ceiling clamp after 60 flapped ticks
    do_reset();
    start_pulse();
    for (int i = 1; i <= 60; i++) begin
      bus.flap = 1'b1;
      tick_step();
      bus.flap = 1'b0;
      step();
      if (i == 59) check_out("ceil59", 476, 64, 1);
    end
    check_out("ceil60", 480, 0, 1);
    bus.flap = 1'b1;
    tick_step();
    bus.flap = 1'b0;
    step();
    check_out("ceil_hold", 480, 0, 1);

    // Fall to the ground: 46 ticks, one dead pulse
    do_reset();
    start_pulse();
    d0 = dead_cnt;
    n  = 0;
    while (bus.state !== 2'd2 && n < 100) begin
      tick_step();
      n++;
    end
    check("ground.ticks", n, 46);
    check_out("ground", 0, 0, 2);
    check("ground.dead", int'(bus.dead), 1);
    step();
    check("ground.dead_next", int'(bus.dead), 0);
    check("ground.pulses", dead_cnt - d0, 1);
    start_pulse();
    check_out("respawn", 240, 0, 0);

    // Collide coincident with a tick and a flap rise
    do_reset();
    start_pulse();
    tick_step();
    tick_step();
    check_out("pre_collide", 238, -16, 1);
    d0 = dead_cnt;
    bus.collide = 1'b1;
    bus.flap    = 1'b1;
    tick_step();
    bus.collide = 1'b0;
    check_out("collide", 237, -24, 2);
    check("collide.dead", int'(bus.dead), 1);
    bus.flap = 1'b0;
    step();
    check("collide.dead_next", int'(bus.dead), 0);
    bus.flap = 1'b1;
    tick_step();
    bus.flap = 1'b0;
    check_out("dead_fall", 235, -32, 2);
    check("collide.pulses", dead_cnt - d0, 1);

    // Reset while a flap is pending
    do_reset();
    start_pulse();
    tick_step();
    bus.flap = 1'b1;
    step();
    rst      = 1'b0;
    bus.flap = 1'b0;
    step();
    check_out("midrst", 240, 0, 0);
    rst = 1'b1;
    step(2);
    tick_step();
    check_out("midrst_idle", 240, 0, 0);
    start_pulse();
    tick_step();
    check_out("midrst_fly", 239, -8, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bird_physics.md
Name: bird_physics

Overview:
- Parametrised successor to the bird vertical-motion block.
- Fixed-point sub-pixel position and velocity; updates only on a per-frame `tick` strobe.
- Adds edge-detected flap latching, terminal velocity, a game-state FSM (IDLE/FLYING/DEAD) and a collision input.
- Sits between button debounce / pipe-collision logic and the renderer, which consumes `y`.

Parameters:
- Y_W, 10, integer pixel width of `y`
- FRAC_W, 4, fractional sub-pixel bits of position and velocity
- V_W, 8, signed velocity width in sub-pixel units
- Y_MIN, 0, ground row (y increases upward)
- Y_MAX, 480, ceiling row
- Y_INIT, 240, spawn row
- GRAVITY, 8, velocity decrement per tick in sub-pixel units (0.5 px/tick²)
- FLAP_VEL, 64, velocity set by an accepted flap (4 px/tick)
- V_TERM, 96, maximum downward speed in sub-pixel units (6 px/tick)
- COOLDOWN_TICKS, 4, flap lockout length; used only with the optional feature

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- tick  in  1  one-cycle frame-update strobe
- start  in  1  level; IDLE->FLYING, DEAD->IDLE
- flap  in  1  debounced button level; rising edge = flap request
- collide  in  1  pipe-collision level from the collision checker
- y  out  Y_W  integer bird row, unsigned, Y_MIN..Y_MAX
- vel  out  V_W  signed velocity, sub-pixel units
- state  out  2  0=IDLE, 1=FLYING, 2=DEAD
- dead  out  1  one-cycle pulse on entry to DEAD

Behaviour:
- Reset (rst=0 at posedge clk):
  - Outputs: pos=Y_INIT<<FRAC_W, vel=0, state=IDLE, dead=0.
  - Internal: flap edge register and pending flag cleared; cooldown counter cleared.
- Position and arithmetic:
  - pos is signed, Y_W+FRAC_W+1 bits; y = pos[Y_W+FRAC_W-1:FRAC_W], i.e. floor.
  - All sums are computed at one extra bit, then clamped; no wrap-around is permitted anywhere.
- Flap latch:
  - flap_q is registered every clk; rise = flap & ~flap_q.
  - A rise sets `pending`, which is held until the next tick or until state leaves FLYING.
  - A rise coincident with a tick is applied on that same tick.
- IDLE:
  - pos and vel are held at spawn values; tick has no effect.
  - start=1 or a flap rise -> FLYING on the next clk.
  - A flap rise that causes this transition sets `pending`.
- FLYING, on tick:
  - v1 = pending ? FLAP_VEL : max(vel-GRAVITY, -V_TERM).
  - p1 = pos + v1; the new velocity is applied on the same tick (zero-lag flap).
  - If p1 >= Y_MAX<<FRAC_W: pos=Y_MAX<<FRAC_W, vel=0; state stays FLYING.
  - If p1 <= Y_MIN<<FRAC_W: pos=Y_MIN<<FRAC_W, vel=0, state -> DEAD, dead=1.
  - Otherwise pos=p1, vel=v1.
  - `pending` is cleared.
  - Outside tick, pos and vel hold.
- FLYING, collide=1 on any clk:
  - state -> DEAD and dead=1 on the next clk.
  - If coincident with tick, the tick update still runs with pending forced to 0.
  - Collide has priority over the ceiling clamp.
- DEAD:
  - Flaps are ignored and pending is held at 0.
  - On tick, the bird falls under gravity/V_TERM until clamped at Y_MIN with vel=0.
  - start=1 -> IDLE next clk, with pos/vel reloaded to spawn values.
- dead pulse:
  - Asserted exactly one clk per entry into DEAD.
  - Ground contact and collide together produce a single pulse.
- Reset mid-operation: wins over every other event in that cycle.

Optional Feature:
- Macro: BIRD_FLAP_COOLDOWN_EN.
- Defined:
  - An accepted flap loads a counter with COOLDOWN_TICKS; the counter decrements on each tick.
  - Rises while counter≠0 are discarded and do not set pending.
  - The counter is cleared on reset and on leaving FLYING.
- Undefined: every rise is accepted and no counter is synthesised.

Decomposition:
- Package bird_pkg holds:
  - state encoding constants (IDLE/FLYING/DEAD);
  - default widths Y_W, FRAC_W, V_W;
  - screen bounds Y_MIN, Y_MAX, Y_INIT.
- Sub-module flap_latch holds edge detect, pending flag and (optional) cooldown counter.
  - Its outputs are `take_flap`, sampled on tick, and a clear input driven by the FSM.

Test Plan:
1. Reset: rst=0 for 2 clks -> y=240, vel=0, state=0, dead=0.
2. Free fall: start pulse, 1 tick, no flap -> vel=-8, y=239. Then 12 more ticks -> vel=-96, and vel stays -96 on later ticks.
3. Flap timing: flap rise 3 clks before a tick from y=240, vel=0 -> after that tick vel=64, y=244. A second rise coincident with the next tick -> vel=64, y=248.
4. Ceiling: flap rise before every tick from y=240 -> y reaches 480 after 60 ticks. Then vel=0 and state=1 (FLYING); further flaps hold y=480.
5. Ground and collide:
   - Fall from spawn until y=0 -> vel=0, state=2, dead high for exactly one clk.
   - In a separate run, collide=1 coincident with tick -> a single dead pulse and y keeps falling on subsequent ticks.
6. Reset mid-flight: rst=0 while FLYING with pending flap -> next clk y=240, vel=0, state=0, and no flap is applied after reset releases.
